// File: rtl/dma_regs_mc.sv
// rtl/dma_regs_mc.sv - multi-channel AXI4-Lite DMA control/status register slave
module dma_regs_mc #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_NUM_CH           = 2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*C_NUM_CH-1:0]          o_src_addr,
    output logic [32*C_NUM_CH-1:0]          o_dst_addr,
    output logic [32*C_NUM_CH-1:0]          o_trf_len,
    output logic [C_NUM_CH-1:0]             o_dma_start,
    input  logic [C_NUM_CH-1:0]             i_dma_done,
    input  logic [C_NUM_CH-1:0]             i_dma_err,
    output logic                            o_interrupt
);
    localparam int NC = C_NUM_CH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int BW = AW - 5;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] st);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = st[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    logic          rst_done, aw_held, w_held, bvalid_q, rvalid_q;
    logic [AW-1:0] aw_addr_q;
    logic [31:0]   w_data_q, rdata_q;
    logic [3:0]    w_strb_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [NC-1:0] irq_status_q, irq_enable_q, busy_q, done_q, err_q;
    logic [31:0]   src_q [NC];
    logic [31:0]   dst_q [NC];
    logic [31:0]   len_q [NC];

    logic          aw_hs, w_hs, ar_hs, do_write;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data, rd_data_d;
    logic [3:0]    wr_strb;
    logic [BW-1:0] wr_blk, rd_blk;
    logic [2:0]    wr_off, rd_off;
    logic          wr_mapped, wr_irq_st, wr_irq_en, rd_mapped;
    logic [NC-1:0] wr_ctrl, wr_src, wr_dst, wr_len;
    logic [NC-1:0] start_req, go, zero_start, done_ev, err_ev, irq_set, irq_clr;
    logic          unused_ok;

    // Readies are held low while in reset so the slave never handshakes mid-reset.
    assign S_AXI_AWREADY = rst_done & ~aw_held & ~bvalid_q;
    assign S_AXI_WREADY  = rst_done & ~w_held & ~bvalid_q;
    assign S_AXI_ARREADY = rst_done & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign do_write = (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_addr  = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data  = w_held ? w_data_q : S_AXI_WDATA;
    assign wr_strb  = w_held ? w_strb_q : S_AXI_WSTRB;
    assign wr_blk   = wr_addr[AW-1:5];
    assign wr_off   = wr_addr[4:2];
    assign rd_blk   = S_AXI_ARADDR[AW-1:5];
    assign rd_off   = S_AXI_ARADDR[4:2];
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        wr_mapped = 1'b0; wr_irq_st = 1'b0; wr_irq_en = 1'b0;
        wr_ctrl = '0; wr_src = '0; wr_dst = '0; wr_len = '0;
        if (wr_blk == '0) begin
            case (wr_off)
                3'd0: begin wr_mapped = 1'b1; wr_irq_st = 1'b1; end
                3'd1: begin wr_mapped = 1'b1; wr_irq_en = 1'b1; end
                3'd2: wr_mapped = 1'b1;
                default: ;
            endcase
        end
        for (int n = 0; n < NC; n++) begin
            if (wr_blk == BW'(n + 1)) begin
                case (wr_off)
                    3'd0: begin wr_mapped = 1'b1; wr_ctrl[n] = 1'b1; end
                    3'd1: wr_mapped = 1'b1;
                    3'd2: begin wr_mapped = 1'b1; wr_src[n] = 1'b1; end
                    3'd3: begin wr_mapped = 1'b1; wr_dst[n] = 1'b1; end
                    3'd4: begin wr_mapped = 1'b1; wr_len[n] = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_mapped = 1'b0;
        if (rd_blk == '0) begin
            case (rd_off)
                3'd0: begin rd_mapped = 1'b1; rd_data_d = 32'(irq_status_q); end
                3'd1: begin rd_mapped = 1'b1; rd_data_d = 32'(irq_enable_q); end
                3'd2: begin rd_mapped = 1'b1; rd_data_d = {16'h0001, 8'h00, 8'(C_NUM_CH)}; end
                default: ;
            endcase
        end
        for (int n = 0; n < NC; n++) begin
            if (rd_blk == BW'(n + 1)) begin
                case (rd_off)
                    3'd0: rd_mapped = 1'b1;
                    3'd1: begin rd_mapped = 1'b1; rd_data_d = {29'd0, err_q[n], done_q[n], busy_q[n]}; end
                    3'd2: begin rd_mapped = 1'b1; rd_data_d = src_q[n]; end
                    3'd3: begin rd_mapped = 1'b1; rd_data_d = dst_q[n]; end
                    3'd4: begin rd_mapped = 1'b1; rd_data_d = len_q[n]; end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_src_addr = '0; o_dst_addr = '0; o_trf_len = '0;
        start_req = '0; go = '0; zero_start = '0;
        for (int n = 0; n < NC; n++) begin
            o_src_addr[32*n +: 32] = src_q[n];
            o_dst_addr[32*n +: 32] = dst_q[n];
            o_trf_len[32*n +: 32]  = len_q[n];
            start_req[n]  = do_write & wr_ctrl[n] & wr_data[0] & wr_strb[0];
            go[n]         = start_req[n] & ~busy_q[n] & (len_q[n] != '0);
            zero_start[n] = start_req[n] & ~busy_q[n] & (len_q[n] == '0);
        end
        done_ev = i_dma_done & busy_q;
        err_ev  = i_dma_err & busy_q;
        irq_set = done_ev | err_ev | zero_start;
        irq_clr = (do_write & wr_irq_st & wr_strb[0]) ? wr_data[NC-1:0] : '0;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rst_done <= 1'b0; aw_held <= 1'b0; w_held <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
            bvalid_q <= 1'b0; bresp_q <= 2'b00;
            rvalid_q <= 1'b0; rresp_q <= 2'b00; rdata_q <= '0;
            irq_status_q <= '0; irq_enable_q <= '0;
            busy_q <= '0; done_q <= '0; err_q <= '0;
            o_dma_start <= '0; o_interrupt <= 1'b0;
            for (int n = 0; n < NC; n++) begin
                src_q[n] <= '0; dst_q[n] <= '0; len_q[n] <= '0;
            end
        end else begin
            rst_done <= 1'b1;
            if (aw_hs) begin aw_held <= 1'b1; aw_addr_q <= S_AXI_AWADDR; end
            if (w_hs) begin w_held <= 1'b1; w_data_q <= S_AXI_WDATA; w_strb_q <= S_AXI_WSTRB; end
            if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
            if (do_write) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? 2'b00 : 2'b10;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_d;
                rresp_q  <= rd_mapped ? 2'b00 : 2'b10;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
            // A set event in the same cycle as a W1C clear must win.
            irq_status_q <= (irq_status_q & ~irq_clr) | irq_set;
            if (do_write && wr_irq_en && wr_strb[0]) irq_enable_q <= wr_data[NC-1:0];
            o_interrupt <= |(irq_status_q & irq_enable_q);
            o_dma_start <= go;
            for (int n = 0; n < NC; n++) begin
                if (do_write && wr_src[n] && !busy_q[n]) src_q[n] <= apply_strb(src_q[n], wr_data, wr_strb);
                if (do_write && wr_dst[n] && !busy_q[n]) dst_q[n] <= apply_strb(dst_q[n], wr_data, wr_strb);
                if (do_write && wr_len[n] && !busy_q[n]) len_q[n] <= apply_strb(len_q[n], wr_data, wr_strb);
                if (busy_q[n]) begin
                    if (done_ev[n] || err_ev[n]) busy_q[n] <= 1'b0;
                    if (done_ev[n]) done_q[n] <= 1'b1;
                    if (err_ev[n]) err_q[n] <= 1'b1;
                end else if (start_req[n]) begin
                    // A zero-length start completes immediately.
                    busy_q[n] <= go[n];
                    done_q[n] <= zero_start[n];
                    err_q[n]  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_regs_mc.sv
// tb/tb_dma_regs_mc.sv - directed scoreboard bench for dma_regs_mc
module tb_dma_regs_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [63:0] src_addr, dst_addr, trf_len;
    logic [1:0]  dma_start, dma_done, dma_err;
    logic        irq;

    int tests = 0;
    int fails = 0;
    logic [1:0]  start_seen, start_after;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 clk = ~clk;

    dma_regs_mc #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .C_NUM_CH(2)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .o_src_addr(src_addr), .o_dst_addr(dst_addr), .o_trf_len(trf_len),
        .o_dma_start(dma_start), .i_dma_done(dma_done), .i_dma_err(dma_err), .o_interrupt(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                             input logic [1:0] err_mask);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        logic [1:0] e;
        bq.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            if ((aw_done || hs_aw) && (w_done || hs_w)) dma_err = err_mask;
            step();
            dma_err = '0;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            cyc++;
            if (cyc > 50) begin
                chk("write_timeout", 32'd0, 32'd1);
                break;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_next_cycle", 32'(bvalid), 32'd1);
        start_seen = dma_start;
        step();
        chk("bvalid_held", 32'(bvalid), 32'd1);
        bready = 1'b1;
        e = bq.pop_front();
        chk("bresp", 32'(bresp), 32'(e));
        step();
        bready = 1'b0;
        start_after = dma_start;
        chk("bvalid_cleared", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        int cyc = 0;
        bit hs = 0;
        logic [31:0] d0;
        logic [33:0] e;
        rq.push_back({exp_resp, exp_data});
        araddr = addr;
        while (!hs) begin
            arvalid = 1'b1;
            hs = arready;
            step();
            cyc++;
            if (cyc > 50) begin
                chk("read_timeout", 32'd0, 32'd1);
                break;
            end
        end
        arvalid = 1'b0;
        chk("rvalid_next_cycle", 32'(rvalid), 32'd1);
        d0 = rdata;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("rdata_stable", rdata, d0);
            chk("rvalid_stable", 32'(rvalid), 32'd1);
        end
        rready = 1'b1;
        e = rq.pop_front();
        chk(tag, rdata, e[31:0]);
        chk({tag, "_rresp"}, 32'(rresp), 32'(e[33:32]));
        step();
        rready = 1'b0;
        chk("rvalid_cleared", 32'(rvalid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; dma_done = '0; dma_err = '0;
        repeat (3) step();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_start_irq", {29'd0, dma_start, irq}, 32'd0);
        chk("rst_src", src_addr[31:0] | src_addr[63:32], 32'd0);
        rst = 1'b0;
        step();
        chk("awready_after_rst", 32'(awready), 32'd1);

        axi_read("info", 8'h08, 32'h0001_0002, 2'b00, 0);

        // AW first, W three cycles later
        axi_write(8'h28, 32'h1000, 4'hF, 0, 3, 2'b00, 2'b00);
        axi_write(8'h2C, 32'h2000, 4'hF, 0, 3, 2'b00, 2'b00);
        axi_write(8'h30, 32'h40, 4'hF, 0, 3, 2'b00, 2'b00);
        chk("src0_out", src_addr[31:0], 32'h1000);
        chk("dst0_out", dst_addr[31:0], 32'h2000);
        chk("len0_out", trf_len[31:0], 32'h40);
        axi_write(8'h20, 32'h1, 4'hF, 0, 3, 2'b00, 2'b00);
        chk("start0_pulse", 32'(start_seen), 32'h1);
        chk("start0_one_cycle", 32'(start_after), 32'h0);
        axi_read("status0_busy", 8'h24, 32'h1, 2'b00, 0);

        // busy channel ignores start and parameter writes
        axi_write(8'h20, 32'h1, 4'hF, 0, 0, 2'b00, 2'b00);
        chk("start_while_busy", 32'(start_seen), 32'h0);
        axi_write(8'h28, 32'hFFFF, 4'hF, 0, 0, 2'b00, 2'b00);
        chk("src0_locked", src_addr[31:0], 32'h1000);
        axi_read("status0_still_busy", 8'h24, 32'h1, 2'b00, 0);

        dma_done = 2'b01;
        step();
        dma_done = 2'b00;
        axi_read("status0_done", 8'h24, 32'h2, 2'b00, 0);
        axi_read("irq_status_ch0", 8'h00, 32'h1, 2'b00, 0);
        chk("irq_masked", 32'(irq), 32'd0);
        axi_write(8'h04, 32'h1, 4'hF, 0, 0, 2'b00, 2'b00);
        chk("irq_enabled", 32'(irq), 32'd1);

        // start channel 1, then clear bit0 in the same cycle as an err on channel 1
        axi_write(8'h50, 32'h10, 4'hF, 0, 0, 2'b00, 2'b00);
        axi_write(8'h40, 32'h1, 4'hF, 1, 0, 2'b00, 2'b00);
        chk("start1_pulse", 32'(start_seen), 32'h2);
        axi_write(8'h00, 32'h1, 4'hF, 0, 2, 2'b00, 2'b10);
        chk("irq_after_w1c", 32'(irq), 32'd0);
        axi_read("irq_status_err1", 8'h00, 32'h2, 2'b00, 0);
        axi_read("status1_err", 8'h44, 32'h4, 2'b00, 0);

        // zero-length start
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, 2'b00, 2'b00);
        axi_read("irq_status_cleared", 8'h00, 32'h0, 2'b00, 0);
        axi_write(8'h50, 32'h0, 4'hF, 0, 0, 2'b00, 2'b00);
        axi_write(8'h40, 32'h1, 4'hF, 0, 0, 2'b00, 2'b00);
        chk("zero_len_no_pulse", 32'(start_seen), 32'h0);
        chk("zero_len_no_pulse_after", 32'(start_after), 32'h0);
        axi_read("status1_zero_len", 8'h44, 32'h2, 2'b00, 0);
        axi_read("irq_status_zero_len", 8'h00, 32'h2, 2'b00, 0);

        // unmapped accesses
        axi_read("unmapped_read", 8'h60, 32'h0, 2'b10, 4);
        axi_write(8'h34, 32'hDEAD, 4'hF, 0, 0, 2'b10, 2'b00);
        axi_read("len0_unchanged", 8'h30, 32'h40, 2'b00, 0);
        axi_write(8'h0C, 32'h3, 4'hF, 0, 0, 2'b10, 2'b00);
        axi_read("irq_enable_unchanged", 8'h04, 32'h1, 2'b00, 0);

        // W before AW with partial strobes, then AW/W together
        axi_write(8'h28, 32'hAABB_CCDD, 4'b0101, 2, 0, 2'b00, 2'b00);
        chk("src0_wstrb", src_addr[31:0], 32'h00BB_10DD);
        axi_write(8'h2C, 32'h3000, 4'hF, 0, 0, 2'b00, 2'b00);
        chk("dst0_same_cycle", dst_addr[31:0], 32'h3000);

        // reset while AW is latched but W still pending
        awaddr = 8'h28; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        wdata = 32'h5555; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("no_bvalid_after_reset", 32'(bvalid), 32'd0);
            step();
        end
        axi_read("src0_after_reset", 8'h28, 32'h0, 2'b00, 0);
        axi_read("irq_en_after_reset", 8'h04, 32'h0, 2'b00, 0);
        axi_read("status0_after_reset", 8'h24, 32'h0, 2'b00, 0);
        axi_read("irq_st_after_reset", 8'h00, 32'h0, 2'b00, 0);
        chk("irq_after_reset", 32'(irq), 32'd0);
        chk("src_out_after_reset", src_addr[31:0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_regs_mc.md
# dma_regs_mc

Multi-channel AXI4-Lite control/status register slave for the DMA subsystem. It replaces the single-channel register file and drives C_NUM_CH independent DMA cores, each with its own source, destination, length and start pulse. It adds per-channel busy/done/error status, a global write-1-to-clear interrupt pending register with enable mask, and SLVERR on unmapped accesses. Write address and write data channels are accepted independently.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8: AXI address width; must cover 0x20*(C_NUM_CH+1).
- C_NUM_CH, 2: number of DMA channels, 1..4.
- S_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave ports; AWPROT/ARPROT are ignored.
- o_src_addr  out  32*C_NUM_CH  channel n occupies bits [32n+31:32n]; o_dst_addr and o_trf_len are packed the same way.
- o_dma_start  out  C_NUM_CH  one-cycle start pulse per channel.
- i_dma_done  in  C_NUM_CH  one-cycle completion pulse per channel.
- i_dma_err  in  C_NUM_CH  one-cycle error pulse per channel.
- o_interrupt  out  1  level output, equal to |(IRQ_STATUS & IRQ_ENABLE).

## Operation
- Global registers:
  - 0x00 IRQ_STATUS: bit n is pending for channel n; write 1 clears (W1C).
  - 0x04 IRQ_ENABLE: read/write, bits [C_NUM_CH-1:0]; upper bits read 0.
  - 0x08 INFO: read-only, {16'h0001, 8'h0, C_NUM_CH[7:0]}.
- Channel n registers, base 0x20*(n+1):
  - +0x00 CTRL: bit0 START; writing 1 requests a start; always reads 0.
  - +0x04 STATUS: read-only; bit0 BUSY, bit1 DONE (sticky), bit2 ERR (sticky).
  - +0x08 SRC, +0x0C DST, +0x10 LEN: read/write.
- Unmapped addresses (including channel n >= C_NUM_CH and offsets above +0x10):
  - Writes have no effect and return BRESP=2'b10.
  - Reads return RDATA=0 and RRESP=2'b10.
  - Mapped accesses return OKAY (2'b00).
- WSTRB is applied per byte to SRC, DST, LEN and IRQ_ENABLE. For IRQ_STATUS and CTRL, a bit is acted on only if its byte strobe is set.
- Accepted start (START written with 1, BUSY=0, LEN!=0):
  - o_dma_start[n] pulses for one cycle.
  - BUSY is set; DONE and ERR are cleared.
- Start with LEN=0:
  - No pulse is generated.
  - DONE is set and IRQ_STATUS[n] is set in the commit cycle.
- Start while BUSY=1 is ignored; no pulse, no status change.
- Writes to SRC, DST or LEN while BUSY=1 are ignored but still return OKAY. The outputs stay stable for the whole transfer.
- i_dma_done[n] while BUSY: clears BUSY, sets DONE, sets IRQ_STATUS[n].
- i_dma_err[n] while BUSY: clears BUSY, sets ERR, sets IRQ_STATUS[n].
- If i_dma_done and i_dma_err arrive together, both DONE and ERR are set.
- i_dma_done or i_dma_err while not BUSY is ignored.
- If a W1C clear and a set event hit the same IRQ_STATUS bit in the same cycle, the set wins.

## Timing
- Reset values:
  - All registers 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, o_dma_start and o_interrupt all 0.
  - BRESP, RRESP and RDATA all 0.
- Reset asserted mid-transaction discards any latched AW, W or AR. No BVALID or RVALID is issued afterwards for the aborted transaction.
- Write channel:
  - AWREADY=1 when no address is held and BVALID=0.
  - WREADY=1 when no data is held and BVALID=0.
  - Each ready drops the cycle after its handshake.
  - AW and W may arrive in any order or in the same cycle. Only one write is outstanding at a time.
  - Let N be the cycle in which the later of the two handshakes completes. The register commit, o_dma_start pulse and BVALID=1 all occur in cycle N+1.
  - BVALID holds until BREADY; the readies return to 1 the cycle after the B handshake.
- Read channel:
  - ARREADY=1 when RVALID=0 and no read is pending.
  - An AR handshake in cycle N gives RVALID=1 with RDATA/RRESP in cycle N+1, held stable until RREADY.
  - RDATA samples register state as of cycle N.
- o_interrupt is registered: it updates the cycle after IRQ_STATUS or IRQ_ENABLE changes.
- The pulse-to-status path is one cycle: i_dma_done in cycle N makes STATUS and IRQ_STATUS visible from cycle N+1.

## Test plan
- Reset, then read 0x08 -> RDATA=0x0001_0002 (C_NUM_CH=2), OKAY; all outputs 0.
- AW first, W three cycles later: SRC0=0x1000, DST0=0x2000, LEN0=0x40, then START0.
  - -> BVALID one cycle after the W handshake.
  - -> o_dma_start=2'b01 for exactly one cycle; STATUS0=0x1.
- Channel 0 busy: write START0 again and SRC0=0xFFFF.
  - -> no pulse; o_src_addr[31:0] stays 0x1000.
  - Then pulse i_dma_done[0] -> STATUS0=0x2, IRQ_STATUS=0x1; o_interrupt=0 while IRQ_ENABLE=0.
  - Write IRQ_ENABLE=0x1 -> o_interrupt=1.
  - Write 0x1 to IRQ_STATUS in the same cycle as an i_dma_err[1] pulse on busy channel 1 -> IRQ_STATUS=0x2, o_interrupt=0.
- START1 with LEN1=0 -> no o_dma_start[1]; STATUS1=0x2; IRQ_STATUS[1]=1.
- Read 0x60 and write 0x34 (C_NUM_CH=2) -> RRESP=2'b10 with RDATA=0, BRESP=2'b10, no register changes. Hold RREADY low for 4 cycles -> RDATA/RVALID stable.
- Assert S_AXI_ARESET while AW is latched but W is pending -> no BVALID afterwards, all registers read 0, o_interrupt=0.
